seg_scheduler: RTL
==================

# seg_scheduler

Display scheduler for the board's four-digit 7-segment display. It arbitrates between the continuous score source and a high-priority message source, such as "PONG" or "GOAL" banners, and drives the multiplexed scan. Each message is held for a fixed number of scan frames. Sits between game logic and the `seg`/`an` pins; one digit is lit per scan step.

## Interface
- `SCAN_DIV`, 4: `segclk` cycles per digit step; must be ≥1.
- `HOLD_FRAMES`, 2: full 4-digit frames a message stays on screen; must be ≥1.
- `BLINK_FRAMES`, 1: frames per on/off phase of message blink (only with `SEG_BLINK_EN`).
- `segclk  input  1`: display clock; all state on rising edge.
- `clr  input  1`: reset; asynchronous, active-high.
- `score_l  input  8`: left player score, two hex digits, drives digits 3..2.
- `score_r  input  8`: right player score, two hex digits, drives digits 1..0.
- `msg_req  input  1`: level request; held until `msg_ack`.
- `msg_glyphs  input  32`: four raw segment patterns; `[31:24]` is the leftmost digit. Must be stable while `msg_req` is high.
- `msg_ack  output  1`: one-cycle pulse when the message is accepted.
- `msg_busy  output  1`: high while a message owns the display.
- `seg  output  8`: segments, active-low; bit 7 is dp (1 = off).
- `an  output  4`: anodes, active-low; `an[3]` is the leftmost digit.

## Operation
- Prescaler `div` counts 0..SCAN_DIV-1. `scan_tick` is asserted when `div == SCAN_DIV-1`.
- Digit FSM: LEFT → MIDLEFT → MIDRIGHT → RIGHT → LEFT. It advances only on `scan_tick`.
  - On each tick, `seg`/`an` are registered for the *new* state.
  - `an` values are 0111, 1011, 1101, 1110 respectively.
- Frame boundary is `scan_tick` while in RIGHT.
- Score snapshot: `score_l`/`score_r` are latched at every frame boundary, so a frame never tears.
- Source FSM has states SCORE and MSG.
- At a frame boundary, if `msg_req` is high and the FSM is either in SCORE or in MSG with `hold == 0`:
  - latch `msg_glyphs`;
  - load `hold = HOLD_FRAMES-1`;
  - pulse `msg_ack`;
  - enter or stay in MSG.
- Otherwise, at a frame boundary in MSG:
  - if `hold == 0`, return to SCORE;
  - else decrement `hold`.
- Back-to-back messages switch with no score frame between them.
- SCORE digits pass through hex decoder `hex7seg`. Encodings, dp off: 0 → 8'hC0, 1 → 8'hF9, 5 → 8'h92, A → 8'h88, F → 8'h8E.
- MSG digits output the latched glyph byte verbatim.
- `msg_req` raised mid-frame waits for the next boundary. A request in progress is never preempted.

## Timing
- Reset values:
  - `seg = 8'hFF`, `an = 4'hF`, `msg_ack = 0`, `msg_busy = 0`;
  - FSM in RIGHT, so the first tick shows LEFT;
  - source in SCORE, `div = 0`, snapshots 0.
- First lit digit appears at edge SCAN_DIV after reset release.
- Source changes take effect on the LEFT digit registered at the same boundary edge:
  - `msg_ack` and the first message digit appear on the same edge;
  - `msg_busy` rises on that edge.
- Message visible for exactly `HOLD_FRAMES*4*SCAN_DIV` cycles.
- `msg_busy` falls on the boundary edge that restores score.
- `clr` mid-message: immediate return to reset values. The pending request is re-evaluated from scratch.

## Configuration
- `SEG_BLINK_EN` defined:
  - in MSG, a frame counter toggles a blink phase every `BLINK_FRAMES` frames, starting visible;
  - during the off phase, `an = 4'hF` while the FSM still scans and `hold` still counts.
- Undefined: no blink logic; messages display steadily.

## Structure
- Package `seg_pkg` holds:
  - digit state encodings (LEFT = 2'b00 .. RIGHT = 2'b11);
  - anode patterns;
  - blank constant `8'hFF`;
  - source state encoding.
- Sub-module `hex7seg` is a combinational 4-bit → 8-bit active-low decoder with dp off.

## Test plan
- **Reset scan:** release `clr`, scores 8'h12/8'h34, SCAN_DIV = 4.
  - Edges 4, 8, 12, 16 give `an` 0111, 1011, 1101, 1110.
  - `seg` sequence is F9, A4, B0, 99.
- **Message accept:** `msg_req` with glyphs 8C,C0,C8,90 ("PONG") raised mid-frame.
  - `msg_ack` pulses at the next boundary together with `seg = 8C`, `an = 0111`.
  - Score returns after 32 cycles (HOLD_FRAMES = 2).
- **Back-to-back:** second request held during the first message.
  - Acked on the boundary where `hold` hits 0.
  - `msg_busy` stays high continuously; no score frame is shown in between.
- **Snapshot:** change `score_l` mid-frame.
  - Displayed digits keep the old value until the next frame's LEFT digit.
- **Reset mid-message:** assert `clr` during MSG.
  - Immediately `seg = FF`, `an = F`, `msg_busy = 0`.
  - After release, the still-high `msg_req` is acked at the first boundary.
- **Blink (SEG_BLINK_EN, BLINK_FRAMES = 1):** a message shows frame 1 lit and frame 2 with `an = F`, then returns to score.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared encodings for the four-digit 7-segment display scheduler: digit and
// source states, anode patterns and digit/byte selection helpers.
package seg_pkg;

  typedef enum logic [1:0] {
    DigLeft     = 2'b00,
    DigMidLeft  = 2'b01,
    DigMidRight = 2'b10,
    DigRight    = 2'b11
  } digit_e;

  typedef enum logic {
    SrcScore = 1'b0,
    SrcMsg   = 1'b1
  } src_e;

  localparam logic [3:0] AnLeft     = 4'b0111;
  localparam logic [3:0] AnMidLeft  = 4'b1011;
  localparam logic [3:0] AnMidRight = 4'b1101;
  localparam logic [3:0] AnRight    = 4'b1110;
  localparam logic [3:0] AnOff      = 4'hF;
  localparam logic [7:0] SegBlank   = 8'hFF;

  function automatic logic [3:0] an_pattern(input digit_e d);
    logic [3:0] a;
    a = AnOff;
    unique case (d)
      DigLeft:     a = AnLeft;
      DigMidLeft:  a = AnMidLeft;
      DigMidRight: a = AnMidRight;
      DigRight:    a = AnRight;
      default:     a = AnOff;
    endcase
    return a;
  endfunction

  // Leftmost digit lives in the most significant byte/nibble.
  function automatic logic [7:0] pick_byte(input logic [31:0] v, input digit_e d);
    logic [7:0] b;
    b = SegBlank;
    unique case (d)
      DigLeft:     b = v[31:24];
      DigMidLeft:  b = v[23:16];
      DigMidRight: b = v[15:8];
      DigRight:    b = v[7:0];
      default:     b = SegBlank;
    endcase
    return b;
  endfunction

  function automatic logic [3:0] pick_nibble(input logic [15:0] v, input digit_e d);
    logic [3:0] n;
    n = 4'h0;
    unique case (d)
      DigLeft:     n = v[15:12];
      DigMidLeft:  n = v[11:8];
      DigMidRight: n = v[7:4];
      DigRight:    n = v[3:0];
      default:     n = 4'h0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/seg_scheduler_hex7seg.sv
// Combinational hex digit to active-low 7-segment decoder, decimal point off.
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [7:0] seg_o
);

  always_comb begin
    seg_o = SegBlank;
    unique case (hex_i)
      4'h0: seg_o = 8'hC0;
      4'h1: seg_o = 8'hF9;
      4'h2: seg_o = 8'hA4;
      4'h3: seg_o = 8'hB0;
      4'h4: seg_o = 8'h99;
      4'h5: seg_o = 8'h92;
      4'h6: seg_o = 8'h82;
      4'h7: seg_o = 8'hF8;
      4'h8: seg_o = 8'h80;
      4'h9: seg_o = 8'h90;
      4'hA: seg_o = 8'h88;
      4'hB: seg_o = 8'h83;
      4'hC: seg_o = 8'hC6;
      4'hD: seg_o = 8'hA1;
      4'hE: seg_o = 8'h86;
      4'hF: seg_o = 8'h8E;
      default: seg_o = SegBlank;
    endcase
  end

endmodule

// File: rtl/seg_scheduler.sv
// Multiplexed 7-segment scan with score/message arbitration at frame boundaries.
// Define SEG_BLINK_EN to blank the anodes on alternate BLINK_FRAMES phases of a message.
module seg_scheduler
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 4,
  parameter int unsigned HOLD_FRAMES  = 2,
  parameter int unsigned BLINK_FRAMES = 1
) (
  input  logic        segclk,
  input  logic        clr,
  input  logic [7:0]  score_l,
  input  logic [7:0]  score_r,
  input  logic        msg_req,
  input  logic [31:0] msg_glyphs,
  output logic        msg_ack,
  output logic        msg_busy,
  output logic [7:0]  seg,
  output logic [3:0]  an
);

  localparam int unsigned DivW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned HoldW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [DivW-1:0]  DivLast  = DivW'(SCAN_DIV - 1);
  localparam logic [HoldW-1:0] HoldLoad = HoldW'(HOLD_FRAMES - 1);

  if (SCAN_DIV < 1 || HOLD_FRAMES < 1 || BLINK_FRAMES < 1) begin : g_param_check
    $error("seg_scheduler: SCAN_DIV, HOLD_FRAMES and BLINK_FRAMES must be >= 1");
  end

  logic [DivW-1:0]  div_q, div_d;
  digit_e           dig_q, dig_d;
  src_e             src_q, src_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [31:0]      glyph_q, glyph_d;
  logic [15:0]      snap_q, snap_d;
  logic [7:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;
  logic             ack_q, ack_d;
  logic             scan_tick, frame_bnd, accept;
  logic [3:0]       nibble;
  logic [7:0]       hex_seg;

`ifdef SEG_BLINK_EN
  localparam int unsigned BlinkW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_FRAMES - 1);
  logic [BlinkW-1:0] bcnt_q, bcnt_d;
  logic              blank_q, blank_d;
`endif

  assign scan_tick = (div_q == DivLast);
  assign frame_bnd = scan_tick && (dig_q == DigRight);
  assign accept    = frame_bnd && msg_req && ((src_q == SrcScore) || (hold_q == '0));

  always_comb begin
    div_d   = scan_tick ? '0 : div_q + DivW'(1);
    dig_d   = scan_tick ? digit_e'(dig_q + 2'd1) : dig_q;
    src_d   = src_q;
    hold_d  = hold_q;
    glyph_d = glyph_q;
    snap_d  = snap_q;
    ack_d   = 1'b0;
    if (frame_bnd) begin
      snap_d = {score_l, score_r};
      if (accept) begin
        glyph_d = msg_glyphs;
        hold_d  = HoldLoad;
        src_d   = SrcMsg;
        ack_d   = 1'b1;
      end else if (src_q == SrcMsg) begin
        if (hold_q == '0) src_d = SrcScore;
        else              hold_d = hold_q - HoldW'(1);
      end
    end
  end

  // Decode from next-state values so the boundary edge already shows the new frame.
  assign nibble = pick_nibble(snap_d, dig_d);

  hex7seg u_hex7seg (
    .hex_i (nibble),
    .seg_o (hex_seg)
  );

  always_comb begin
    seg_d = seg_q;
    an_d  = an_q;
`ifdef SEG_BLINK_EN
    bcnt_d  = bcnt_q;
    blank_d = blank_q;
    if (accept) begin
      bcnt_d  = '0;
      blank_d = 1'b0;
    end else if (frame_bnd && (src_q == SrcMsg) && (src_d == SrcMsg)) begin
      if (bcnt_q == BlinkLast) begin
        bcnt_d  = '0;
        blank_d = ~blank_q;
      end else begin
        bcnt_d = bcnt_q + BlinkW'(1);
      end
    end
`endif
    if (scan_tick) begin
      seg_d = (src_d == SrcMsg) ? pick_byte(glyph_d, dig_d) : hex_seg;
      an_d  = an_pattern(dig_d);
`ifdef SEG_BLINK_EN
      if ((src_d == SrcMsg) && blank_d) an_d = AnOff;
`endif
    end
  end

  always_ff @(posedge segclk or posedge clr) begin
    if (clr) begin
      div_q   <= '0;
      dig_q   <= DigRight;
      src_q   <= SrcScore;
      hold_q  <= '0;
      glyph_q <= '0;
      snap_q  <= '0;
      seg_q   <= SegBlank;
      an_q    <= AnOff;
      ack_q   <= 1'b0;
`ifdef SEG_BLINK_EN
      bcnt_q  <= '0;
      blank_q <= 1'b0;
`endif
    end else begin
      div_q   <= div_d;
      dig_q   <= dig_d;
      src_q   <= src_d;
      hold_q  <= hold_d;
      glyph_q <= glyph_d;
      snap_q  <= snap_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      ack_q   <= ack_d;
`ifdef SEG_BLINK_EN
      bcnt_q  <= bcnt_d;
      blank_q <= blank_d;
`endif
    end
  end

  assign seg      = seg_q;
  assign an       = an_q;
  assign msg_ack  = ack_q;
  assign msg_busy = (src_q == SrcMsg);

endmodule
